// File: rtl/fm_scan_ctrl_gen2.sv
// ---------------------------------------------------------------------------
// fm_scan_ctrl_gen2
// Feature-map traversal controller. A layer configuration is latched through
// a valid/ready handshake. The map is then walked tile by tile (PE_COLS
// columns per tile), row by row and channel by channel, with the bias pass
// last. One tile is retired per step while running.
//
// Handshake: cfg_ready is a register that is high only in IDLE. A
// configuration transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_valid is ignored while running. step and abort only act in RUN, and
// abort wins over a simultaneous step.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   cfg_valid/cfg_ready   configuration handshake
//   cfg_w/h/c_num         map width/height/channels minus 1
//   cfg_kernel_mode       row-phase divider select (3 behaves as 2)
//   cfg_bit_mode          precision mode, latched only
//   abort, step           terminate layer / tile consumed
//   w/h/c_num, kernel_mode, bit_mode   latched configuration
//   busy                  state == RUN (exposes the FSM state)
//   count_w/h/c           tile origin column, row, channel pass
//   tile_valid_cols       valid columns in the current tile
//   last_tile, last_row, bias_pass     combinational position flags
//   is_even_row, is_even_even_row, row_phase   row guard outputs
//   done, aborted         one-cycle end-of-layer pulses
// ---------------------------------------------------------------------------
module fm_scan_ctrl_gen2 #(
    parameter int CNT_W     = 8,
    parameter int PE_COLS   = 6,
    parameter int PHASE_MOD = 3,
    parameter int PHASE_W   = 2,
    parameter int VC_W      = $clog2(PE_COLS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_w_num,
    input  logic [CNT_W-1:0]   cfg_h_num,
    input  logic [CNT_W-1:0]   cfg_c_num,
    input  logic [1:0]         cfg_kernel_mode,
    input  logic               cfg_bit_mode,
    input  logic               abort,
    input  logic               step,
    output logic [CNT_W-1:0]   w_num,
    output logic [CNT_W-1:0]   h_num,
    output logic [CNT_W-1:0]   c_num,
    output logic [1:0]         kernel_mode,
    output logic               bit_mode,
    output logic               busy,
    output logic [CNT_W-1:0]   count_w,
    output logic [CNT_W-1:0]   count_h,
    output logic [CNT_W-1:0]   count_c,
    output logic [VC_W-1:0]    tile_valid_cols,
    output logic               last_tile,
    output logic               last_row,
    output logic               bias_pass,
    output logic               is_even_row,
    output logic               is_even_even_row,
    output logic [PHASE_W-1:0] row_phase,
    output logic               done,
    output logic               aborted
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CNT_W:0]     PE_COLS_X  = (CNT_W+1)'(PE_COLS);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_MOD - 1);

    state_t             state_q, state_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic [CNT_W-1:0]   w_num_q, w_num_d, h_num_q, h_num_d, c_num_q, c_num_d;
    logic [1:0]         kernel_mode_q, kernel_mode_d;
    logic               bit_mode_q, bit_mode_d;
    logic [CNT_W-1:0]   count_w_q, count_w_d, count_h_q, count_h_d;
    // One extra bit so the bias pass (c_num+1) is reachable when c_num is all ones.
    logic [CNT_W:0]     count_c_q, count_c_d;
    logic               is_even_row_q, is_even_row_d;
    logic               is_even_even_row_q, is_even_even_row_d;
    logic [PHASE_W-1:0] row_phase_q, row_phase_d;
    logic               done_q, done_d, aborted_q, aborted_d;

    logic [CNT_W:0]     w_end, tvc_last;
    logic [1:0]         km_eff;
    logic [CNT_W-1:0]   ph_mask;
    logic               ph_adv;

    // Position flags evaluated one bit wider so w_num = all-ones cannot wrap.
    assign w_end     = {1'b0, count_w_q} + PE_COLS_X;
    assign last_tile = (w_end > {1'b0, w_num_q});
    assign last_row  = (count_h_q == h_num_q);
    assign bias_pass = (count_c_q == ({1'b0, c_num_q} + (CNT_W+1)'(1)));
    assign tvc_last  = {1'b0, w_num_q} - {1'b0, count_w_q} + (CNT_W+1)'(1);
    assign tile_valid_cols = last_tile ? VC_W'(tvc_last) : VC_W'(PE_COLS);

    // Phase advances when the low km_eff bits of the current row are all ones.
    assign km_eff  = (kernel_mode_q == 2'd3) ? 2'd2 : kernel_mode_q;
    assign ph_mask = CNT_W'((32'd1 << km_eff) - 32'd1);
    assign ph_adv  = ((count_h_q & ph_mask) == ph_mask);

    always_comb begin
        state_d            = state_q;
        cfg_ready_d        = cfg_ready_q;
        w_num_d            = w_num_q;
        h_num_d            = h_num_q;
        c_num_d            = c_num_q;
        kernel_mode_d      = kernel_mode_q;
        bit_mode_d         = bit_mode_q;
        count_w_d          = count_w_q;
        count_h_d          = count_h_q;
        count_c_d          = count_c_q;
        is_even_row_d      = is_even_row_q;
        is_even_even_row_d = is_even_even_row_q;
        row_phase_d        = row_phase_q;
        done_d             = 1'b0;
        aborted_d          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    w_num_d            = cfg_w_num;
                    h_num_d            = cfg_h_num;
                    c_num_d            = cfg_c_num;
                    kernel_mode_d      = cfg_kernel_mode;
                    bit_mode_d         = cfg_bit_mode;
                    count_w_d          = '0;
                    count_h_d          = '0;
                    count_c_d          = '0;
                    is_even_row_d      = 1'b0;
                    is_even_even_row_d = 1'b0;
                    row_phase_d        = '0;
                    cfg_ready_d        = 1'b0;
                    state_d            = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    aborted_d   = 1'b1;
                    cfg_ready_d = 1'b1;
                end else if (step) begin
                    if (!last_tile) begin
                        count_w_d = count_w_q + CNT_W'(PE_COLS);
                    end else if (!last_row) begin
                        count_w_d     = '0;
                        count_h_d     = count_h_q + 1'b1;
                        is_even_row_d = ~is_even_row_q;
                        if (is_even_row_q) begin
                            is_even_even_row_d = ~is_even_even_row_q;
                        end
                        if (ph_adv) begin
                            row_phase_d = (row_phase_q == PHASE_LAST) ? '0 : row_phase_q + 1'b1;
                        end
                    end else if (!bias_pass) begin
                        count_w_d          = '0;
                        count_h_d          = '0;
                        count_c_d          = count_c_q + 1'b1;
                        is_even_row_d      = 1'b0;
                        is_even_even_row_d = 1'b0;
                        row_phase_d        = '0;
                    end else begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        cfg_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                cfg_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            cfg_ready_q        <= 1'b1;
            w_num_q            <= '0;
            h_num_q            <= '0;
            c_num_q            <= '0;
            kernel_mode_q      <= '0;
            bit_mode_q         <= 1'b0;
            count_w_q          <= '0;
            count_h_q          <= '0;
            count_c_q          <= '0;
            is_even_row_q      <= 1'b0;
            is_even_even_row_q <= 1'b0;
            row_phase_q        <= '0;
            done_q             <= 1'b0;
            aborted_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            cfg_ready_q        <= cfg_ready_d;
            w_num_q            <= w_num_d;
            h_num_q            <= h_num_d;
            c_num_q            <= c_num_d;
            kernel_mode_q      <= kernel_mode_d;
            bit_mode_q         <= bit_mode_d;
            count_w_q          <= count_w_d;
            count_h_q          <= count_h_d;
            count_c_q          <= count_c_d;
            is_even_row_q      <= is_even_row_d;
            is_even_even_row_q <= is_even_even_row_d;
            row_phase_q        <= row_phase_d;
            done_q             <= done_d;
            aborted_q          <= aborted_d;
        end
    end

    assign cfg_ready        = cfg_ready_q;
    assign w_num            = w_num_q;
    assign h_num            = h_num_q;
    assign c_num            = c_num_q;
    assign kernel_mode      = kernel_mode_q;
    assign bit_mode         = bit_mode_q;
    assign busy             = (state_q == S_RUN);
    assign count_w          = count_w_q;
    assign count_h          = count_h_q;
    assign count_c          = count_c_q[CNT_W-1:0];
    assign is_even_row      = is_even_row_q;
    assign is_even_even_row = is_even_even_row_q;
    assign row_phase        = row_phase_q;
    assign done             = done_q;
    assign aborted          = aborted_q;

endmodule

// File: tb/tb_fm_scan_ctrl_gen2.sv
// Bench for fm_scan_ctrl_gen2 with default parameters (CNT_W=8, PE_COLS=6,
// PHASE_MOD=3). The driver pushes hand-computed tile positions and end-of-
// layer events into queues; a negedge monitor pops and compares them.
module tb_fm_scan_ctrl_gen2;
  localparam int TW = 34;
  localparam int EW = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_w_num = '0, cfg_h_num = '0, cfg_c_num = '0;
  logic [1:0] cfg_kernel_mode = '0;
  logic       cfg_bit_mode = 1'b0;
  logic       abort = 1'b0, step = 1'b0;
  logic [7:0] w_num, h_num, c_num;
  logic [1:0] kernel_mode;
  logic       bit_mode, busy;
  logic [7:0] count_w, count_h, count_c;
  logic [2:0] tile_valid_cols;
  logic       last_tile, last_row, bias_pass, is_even_row, is_even_even_row;
  logic [1:0] row_phase;
  logic       done, aborted;

  logic [TW-1:0] exp_q[$];
  logic [EW-1:0] evt_q[$];
  int checks = 0;
  int errors = 0;

  fm_scan_ctrl_gen2 dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_w_num(cfg_w_num), .cfg_h_num(cfg_h_num), .cfg_c_num(cfg_c_num),
    .cfg_kernel_mode(cfg_kernel_mode), .cfg_bit_mode(cfg_bit_mode),
    .abort(abort), .step(step), .w_num(w_num), .h_num(h_num), .c_num(c_num),
    .kernel_mode(kernel_mode), .bit_mode(bit_mode), .busy(busy),
    .count_w(count_w), .count_h(count_h), .count_c(count_c),
    .tile_valid_cols(tile_valid_cols), .last_tile(last_tile), .last_row(last_row),
    .bias_pass(bias_pass), .is_even_row(is_even_row), .is_even_even_row(is_even_even_row),
    .row_phase(row_phase), .done(done), .aborted(aborted)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_tile(input int w, input int h, input int c, input int tvc,
                           input int lt, input int lr, input int bp,
                           input int er, input int eer, input int ph);
    exp_q.push_back({8'(w), 8'(h), 8'(c), 3'(tvc), 1'(lt), 1'(lr), 1'(bp),
                     1'(er), 1'(eer), 2'(ph)});
  endtask

  // kind 1 = done, 2 = aborted; w/h/c are the held counter values
  task automatic push_evt(input int kind, input int w, input int h, input int c);
    evt_q.push_back({2'(kind), 8'(w), 8'(h), 8'(c)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input int w, input int h, input int c, input int km, input int bm);
    cfg_w_num = 8'(w); cfg_h_num = 8'(h); cfg_c_num = 8'(c);
    cfg_kernel_mode = 2'(km); cfg_bit_mode = 1'(bm);
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    chk("busy_after_cfg", busy, 1);
    chk("cfg_ready_in_run", cfg_ready, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && step && !abort) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tile_unexpected: got step at w=%0d h=%0d c=%0d, expected none", count_w, count_h, count_c);
        end else begin
          chk("tile", {count_w, count_h, count_c, tile_valid_cols, last_tile, last_row,
                       bias_pass, is_even_row, is_even_even_row, row_phase}, exp_q.pop_front());
        end
      end
      if (done || aborted) begin
        if (evt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL evt_unexpected: got done=%0b aborted=%0b, expected none", done, aborted);
        end else begin
          chk("evt", {done ? 2'd1 : 2'd2, count_w, count_h, count_c}, evt_q.pop_front());
          chk("evt_both", {done, aborted}, done ? 2'b10 : 2'b01);
          chk("evt_cfg_ready", cfg_ready, 1);
          chk("evt_busy", busy, 0);
        end
      end
    end
  end

  int ph_t[8]  = '{0, 0, 1, 1, 2, 2, 0, 0};
  int eer_t[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_counts", {count_w, count_h, count_c, row_phase}, 0);

    // Test 1: basic walk, 12 steps, tiles 6,6,2
    for (int c = 0; c < 2; c++)
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 3; i++)
          push_tile(6*i, h, c, (i == 2) ? 2 : 6, i == 2, h == 1, c == 1, h, 0, h);
    push_evt(1, 12, 1, 1);
    start_cfg(13, 1, 0, 0, 0);
    step = 1'b1;
    tick(12);
    // Now in the done cycle; step and abort in IDLE must be ignored.
    abort = 1'b1;
    tick(3);
    step = 1'b0; abort = 1'b0;
    chk("idle_hold_counts", {count_w, count_h, count_c}, {8'd12, 8'd1, 8'd1});
    chk("idle_busy", busy, 0);

    // Test 2: phase divider, kernel_mode 1
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++)
        push_tile(0, r, c, 6, 1, r == 7, c == 1, r % 2, eer_t[r], ph_t[r]);
    push_evt(1, 0, 7, 1);
    start_cfg(5, 7, 0, 1, 1);
    chk("latched_km_bm", {kernel_mode, bit_mode}, 3'b011);
    step = 1'b1;
    tick(16);
    step = 1'b0;
    tick(1);

    // Test 3: width boundary, 43 tiles per row
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 43; i++)
        push_tile(6*i, 0, c, (i == 42) ? 4 : 6, i == 42, 1, c == 1, 0, 0, 0);
    push_evt(1, 252, 0, 1);
    start_cfg(255, 0, 0, 0, 0);
    step = 1'b1;
    tick(86);
    step = 1'b0;
    tick(1);

    // Test 4: abort after 5 steps with simultaneous step
    for (int i = 0; i < 5; i++)
      push_tile(6*(i % 3), i / 3, 0, (i % 3 == 2) ? 2 : 6, i % 3 == 2, i / 3, 0, i / 3, 0, i / 3);
    push_evt(2, 12, 1, 0);
    start_cfg(13, 1, 0, 0, 0);
    step = 1'b1;
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0; step = 1'b0;
    chk("abort_no_done", done, 0);
    chk("abort_count_w", count_w, 12);
    // New configuration offered in the aborted cycle.
    start_cfg(5, 3, 0, 0, 0);

    // Test 5: cfg_valid ignored in RUN
    cfg_w_num = 8'd99; cfg_h_num = 8'd99; cfg_c_num = 8'd99;
    cfg_valid = 1'b1;
    tick(3);
    cfg_valid = 1'b0;
    chk("run_cfg_ignored", {w_num, h_num, c_num}, {8'd5, 8'd3, 8'd0});

    // Test 6: asynchronous reset mid-row
    for (int r = 0; r < 3; r++)
      push_tile(0, r, 0, 6, 1, 0, 0, r % 2, r == 2, r);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    chk("pre_rst_row", {count_h, is_even_row, is_even_even_row}, {8'd3, 1'b1, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready_busy", {cfg_ready, busy}, 2'b10);
    chk("async_rst_counts", {count_w, count_h, count_c, is_even_row, is_even_even_row, row_phase}, 0);
    chk("async_rst_cfg", {w_num, h_num, c_num}, 0);
    chk("async_rst_pulses", {done, aborted}, 0);
    tick(2);
    rst = 1'b0;
    tick(3);

    chk("tile_q_drained", exp_q.size(), 0);
    chk("evt_q_drained", evt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
